// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Stall/flush scheduler for a five-stage pipeline. It decides each
//            cycle which pipeline registers capture, flush or bubble, based on
//            load-use hazards, taken branches resolved in EX and multi-cycle
//            data-memory accesses. It also keeps saturating stall and flush
//            performance counters.
// Ports    : clk, reset (async, active-high)
//            Rn_ID, Rm_ID, usesRn_ID, usesRm_ID   - ID-stage operand info
//            memRead_EX, regWrite_EX              - EX-stage load / dest reg
//            branchTaken_EX                       - taken branch in EX
//            memAccess_MEM                        - load/store in MEM
//            pc_en .. memwb_en                    - register capture enables
//            ifid_flush, idex_bubble, memwb_bubble - NOP / bubble controls
//            stall_count, flush_count             - saturating counters
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MEM_WAIT = 2,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rn_ID,
    input  logic [4:0]       Rm_ID,
    input  logic             usesRn_ID,
    input  logic             usesRm_ID,
    input  logic             memRead_EX,
    input  logic [4:0]       regWrite_EX,
    input  logic             branchTaken_EX,
    input  logic             memAccess_MEM,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // The wait counter only ever needs to hold MEM_WAIT-1; keep at least one
    // bit so the design still elaborates when MEM_WAIT is 0 or 1.
    localparam int                    c_CNT_BITS = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [c_CNT_BITS-1:0] c_CNT_INIT = c_CNT_BITS'((MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0);
    localparam logic [c_CNT_BITS-1:0] c_CNT_ONE  = c_CNT_BITS'(1);
    localparam logic [CNT_W-1:0]      c_CTR_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      c_CTR_MAX  = '1;
    localparam bit                    c_HAS_WAIT = (MEM_WAIT > 0);
    localparam logic [4:0]            c_XZR      = 5'd31;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_CNT_BITS-1:0] r_cnt;
    logic [c_CNT_BITS-1:0] w_cnt_next;
    logic                  w_lu;
    logic                  w_memstall;
    logic [CNT_W-1:0]      r_stall_count;
    logic [CNT_W-1:0]      r_flush_count;

    // X31 reads as zero, so a load targeting it never creates a dependency.
    assign w_lu = memRead_EX && (regWrite_EX != c_XZR) &&
                  ((usesRn_ID && (Rn_ID == regWrite_EX)) ||
                   (usesRm_ID && (Rm_ID == regWrite_EX)));

    // The WAIT cycle with cnt==0 is the release cycle and is not a stall.
    assign w_memstall = ((r_state == RUN) && memAccess_MEM && c_HAS_WAIT) ||
                        ((r_state == WAIT) && (r_cnt != '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            RUN: begin
                if (memAccess_MEM && c_HAS_WAIT) begin
                    w_state_next = WAIT;
                    w_cnt_next   = c_CNT_INIT;
                end
            end
            WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - c_CNT_ONE;
                end else begin
                    // Release cycle: a memAccess_MEM seen here belongs to the
                    // instruction being released, so it is not re-armed.
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = RUN;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Stage controls: memstall > branch flush > load-use > normal. While reset
    // is asserted the pipeline is left free-running with no squashing.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        if (!reset) begin
            if (w_memstall) begin
                // Front of the pipe frozen; MEM/WB drains a bubble so the
                // stalled access is not written back twice.
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_en     = 1'b0;
                memwb_bubble = 1'b1;
            end else if (branchTaken_EX) begin
                // Squashes the instructions in IF and ID, which also kills
                // any load-use dependency of the ID instruction.
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (w_lu) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (!pc_en && (r_stall_count != c_CTR_MAX)) begin
                r_stall_count <= r_stall_count + c_CTR_ONE;
            end
            if (ifid_flush && (r_flush_count != c_CTR_MAX)) begin
                r_flush_count <= r_flush_count + c_CTR_ONE;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Directed self-checking bench for pipeline_hazard_ctrl. Drives a
//            MEM_WAIT=2/CNT_W=32 instance and a MEM_WAIT=0/CNT_W=2 instance
//            from shared inputs and compares controls and counters against
//            hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    // Control vector order: pc, ifid, idex, exmem, memwb, ifid_flush,
    // idex_bubble, memwb_bubble.
    localparam logic [7:0] c_NORM  = 8'b11111_000;
    localparam logic [7:0] c_LU    = 8'b00111_010;
    localparam logic [7:0] c_MSTL  = 8'b00001_001;
    localparam logic [7:0] c_BR    = 8'b11111_110;

    logic        clk;
    logic        reset;
    logic [4:0]  Rn_ID, Rm_ID, regWrite_EX;
    logic        usesRn_ID, usesRm_ID, memRead_EX, branchTaken_EX, memAccess_MEM;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_bubble, memwb_bubble;
    logic [31:0] stall_count, flush_count;

    logic        b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en;
    logic        b_ifid_flush, b_idex_bubble, b_memwb_bubble;
    logic [1:0]  b_stall_count, b_flush_count;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(.MEM_WAIT(2), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset),
        .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .usesRn_ID(usesRn_ID), .usesRm_ID(usesRm_ID),
        .memRead_EX(memRead_EX), .regWrite_EX(regWrite_EX),
        .branchTaken_EX(branchTaken_EX), .memAccess_MEM(memAccess_MEM),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_hazard_ctrl #(.MEM_WAIT(0), .CNT_W(2)) u_dut_nw (
        .clk(clk), .reset(reset),
        .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .usesRn_ID(usesRn_ID), .usesRm_ID(usesRm_ID),
        .memRead_EX(memRead_EX), .regWrite_EX(regWrite_EX),
        .branchTaken_EX(branchTaken_EX), .memAccess_MEM(memAccess_MEM),
        .pc_en(b_pc_en), .ifid_en(b_ifid_en), .idex_en(b_idex_en),
        .exmem_en(b_exmem_en), .memwb_en(b_memwb_en),
        .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble), .memwb_bubble(b_memwb_bubble),
        .stall_count(b_stall_count), .flush_count(b_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ctl_a();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_bubble, memwb_bubble};
    endfunction

    function automatic logic [7:0] ctl_b();
        return {b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en,
                b_ifid_flush, b_idex_bubble, b_memwb_bubble};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        Rn_ID = 5'd0; Rm_ID = 5'd0; regWrite_EX = 5'd0;
        usesRn_ID = 1'b0; usesRm_ID = 1'b0; memRead_EX = 1'b0;
        branchTaken_EX = 1'b0; memAccess_MEM = 1'b0;
    endtask

    task automatic set_lu();
        memRead_EX = 1'b1; regWrite_EX = 5'd5; Rm_ID = 5'd5; usesRm_ID = 1'b1;
    endtask

    // Advance across one posedge to the next negedge, then settle.
    task automatic next();
        @(negedge clk);
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        set_lu();
        branchTaken_EX = 1'b1;
        memAccess_MEM  = 1'b1;
        @(negedge clk); #1;
        check("reset_ctl", {24'd0, ctl_a()}, {24'd0, c_NORM});
        check("reset_stall", stall_count, 32'd0);
        check("reset_flush", flush_count, 32'd0);

        next(); clear_in(); reset = 1'b0; #1;
        check("normal_ctl", {24'd0, ctl_a()}, {24'd0, c_NORM});

        // Load-use through Rm.
        next(); set_lu(); #1;
        check("lu_rm_ctl", {24'd0, ctl_a()}, {24'd0, c_LU});
        next(); clear_in(); #1;
        check("lu_after_ctl", {24'd0, ctl_a()}, {24'd0, c_NORM});
        check("lu_stall_cnt", stall_count, 32'd1);

        // XZR destination and unused operand do not stall.
        memRead_EX = 1'b1; regWrite_EX = 5'd31; Rn_ID = 5'd31; usesRn_ID = 1'b1; #1;
        check("xzr_ctl", {24'd0, ctl_a()}, {24'd0, c_NORM});
        next(); clear_in();
        memRead_EX = 1'b1; regWrite_EX = 5'd7; Rn_ID = 5'd7; usesRn_ID = 1'b0; #1;
        check("unused_rn_ctl", {24'd0, ctl_a()}, {24'd0, c_NORM});
        next(); clear_in();
        memRead_EX = 1'b1; regWrite_EX = 5'd3; Rn_ID = 5'd3; usesRn_ID = 1'b1; #1;
        check("lu_rn_ctl", {24'd0, ctl_a()}, {24'd0, c_LU});
        next(); clear_in(); #1;
        check("xzr_stall_cnt", stall_count, 32'd2);

        // Back-to-back memory accesses with MEM_WAIT=2.
        memAccess_MEM = 1'b1; #1;
        check("mem1_s0", {24'd0, ctl_a()}, {24'd0, c_MSTL});
        check("nowait_mem_ctl", {24'd0, ctl_b()}, {24'd0, c_NORM});
        next(); #1;
        check("mem1_s1", {24'd0, ctl_a()}, {24'd0, c_MSTL});
        next(); #1;
        check("mem1_release", {24'd0, ctl_a()}, {24'd0, c_NORM});
        check("mem1_stall_cnt", stall_count, 32'd4);
        next(); #1;
        check("mem2_s0", {24'd0, ctl_a()}, {24'd0, c_MSTL});
        next(); #1;
        check("mem2_s1", {24'd0, ctl_a()}, {24'd0, c_MSTL});
        next(); #1;
        check("mem2_release", {24'd0, ctl_a()}, {24'd0, c_NORM});
        next(); clear_in(); #1;
        check("mem2_stall_cnt", stall_count, 32'd6);

        // Branch together with load-use: branch wins, no stall.
        set_lu(); branchTaken_EX = 1'b1; #1;
        check("br_lu_ctl", {24'd0, ctl_a()}, {24'd0, c_BR});
        next(); clear_in(); #1;
        check("br_lu_flush_cnt", flush_count, 32'd1);
        check("br_lu_stall_cnt", stall_count, 32'd6);

        // Branch held across a memory wait: one flush, on release only.
        memAccess_MEM = 1'b1; branchTaken_EX = 1'b1; #1;
        check("br_wait_s0", {24'd0, ctl_a()}, {24'd0, c_MSTL});
        next(); memAccess_MEM = 1'b0; #1;
        check("br_wait_s1", {24'd0, ctl_a()}, {24'd0, c_MSTL});
        next(); #1;
        check("br_wait_release", {24'd0, ctl_a()}, {24'd0, c_BR});
        next(); clear_in(); #1;
        check("br_wait_flush_cnt", flush_count, 32'd2);
        check("br_wait_stall_cnt", stall_count, 32'd8);

        // Reset asserted mid-WAIT (cnt=1).
        memAccess_MEM = 1'b1; #1;
        check("rst_wait_enter", {24'd0, ctl_a()}, {24'd0, c_MSTL});
        next(); reset = 1'b1; #1;
        check("rst_mid_ctl", {24'd0, ctl_a()}, {24'd0, c_NORM});
        check("rst_mid_stall", stall_count, 32'd0);
        check("rst_mid_flush", flush_count, 32'd0);
        next(); reset = 1'b0; memAccess_MEM = 1'b0; #1;
        check("rst_post_ctl", {24'd0, ctl_a()}, {24'd0, c_NORM});
        next(); memAccess_MEM = 1'b1; #1;
        check("rst_post_mem", {24'd0, ctl_a()}, {24'd0, c_MSTL});

        // Counter saturation on the 2-bit instance.
        next(); clear_in(); reset = 1'b1;
        next(); reset = 1'b0; set_lu();
        repeat (5) next();
        clear_in(); branchTaken_EX = 1'b1;
        repeat (4) next();
        clear_in(); #1;
        check("sat_stall_a", stall_count, 32'd5);
        check("sat_flush_a", flush_count, 32'd4);
        check("sat_stall_b", {30'd0, b_stall_count}, 32'd3);
        check("sat_flush_b", {30'd0, b_flush_count}, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Stall/flush scheduler for the five-stage pipelined CPU. Each cycle it decides which pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) capture and which are bubbled or flushed. The decisions cover three cases: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses. It sits beside the datapath, drives the register `enable` and bubble controls, and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- MEM_WAIT, 2: extra cycles a load/store occupies MEM (0 = single-cycle memory)
- CNT_W, 32: width of performance counters

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- Rn_ID  in  5  source register A of instruction in ID
- Rm_ID  in  5  source register B of instruction in ID
- usesRn_ID, usesRm_ID  in  1 each  ID instruction actually reads Rn / Rm
- memRead_EX  in  1  instruction in EX is a load
- regWrite_EX  in  5  destination register of instruction in EX
- branchTaken_EX  in  1  taken branch resolved in EX
- memAccess_MEM  in  1  instruction in MEM is a load or store
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register capture enables
- ifid_flush  out  1  IF/ID loads a NOP
- idex_bubble  out  1  ID/EX loads control-zero bubble (regWrite_E=0, memWrite=0)
- memwb_bubble  out  1  MEM/WB loads regWrite_E=0
- stall_count  out  CNT_W  cycles with pc_en=0, saturating
- flush_count  out  CNT_W  taken-branch flush events, saturating

## Operation
- FSM states: RUN, WAIT. Wait counter `cnt` holds at most MEM_WAIT-1.
- Hazard terms:
  - `lu` = memRead_EX & regWrite_EX!=31 & ((usesRn_ID & Rn_ID==regWrite_EX) | (usesRm_ID & Rm_ID==regWrite_EX)). X31 is XZR and never causes a hazard.
  - `memstall` = (RUN & memAccess_MEM & MEM_WAIT>0) | (WAIT & cnt!=0).
- Priority: memstall > branch flush > load-use > normal.
- memstall:
  - pc_en, ifid_en, idex_en, exmem_en = 0.
  - memwb_en = 1 with memwb_bubble = 1.
  - No flush or bubble is applied elsewhere. A pending branch or load-use waits, because stage contents are frozen.
- Branch (branchTaken_EX, no memstall):
  - All enables = 1, ifid_flush = 1, idex_bubble = 1.
  - flush_count increments.
  - Any simultaneous `lu` is ignored, because the ID instruction is squashed.
- Load-use (`lu`, no memstall, no branch):
  - pc_en = ifid_en = 0.
  - idex_en = 1 with idex_bubble = 1.
  - exmem_en = memwb_en = 1.
- Normal: all enables 1, all flush/bubble 0.
- Transitions:
  - RUN & memAccess_MEM & MEM_WAIT>0 → WAIT, cnt = MEM_WAIT-1.
  - WAIT & cnt!=0 → WAIT, cnt-1.
  - WAIT & cnt==0 → RUN. This is the release cycle: memstall=0 and the normal/branch/lu rules apply.
  - A memAccess_MEM in the cycle after release is a new instruction and re-enters WAIT.
- Counters:
  - stall_count increments in every cycle where pc_en=0 (memstall or lu).
  - Both counters hold at 2^CNT_W-1.

## Timing
- Stage controls are combinational from state, `cnt` and inputs, valid within the same cycle. State, `cnt` and counters update on posedge clk.
- Memory access costs exactly MEM_WAIT stall cycles, then 1 release cycle.
- A load-use hazard costs exactly 1 stall cycle.
- A taken branch costs 2 squashed instructions and 0 stall cycles.
- Reset (async, any time, including mid-WAIT):
  - State = RUN, cnt = 0, stall_count = flush_count = 0.
  - While reset is high: all enables 1, all flush/bubble 0, counters read 0.
  - First cycle after deassert behaves as RUN.
- MEM_WAIT=0: the WAIT state is unreachable and memAccess_MEM has no effect.

## Test plan
- Load-use: memRead_EX=1, regWrite_EX=5, Rm_ID=5, usesRm_ID=1 → exactly one cycle with pc_en=ifid_en=0, idex_bubble=1; stall_count=1.
- XZR/unused operand: regWrite_EX=31 with Rn_ID=31, or Rn match with usesRn_ID=0 → no stall, all enables 1.
- Memory wait, MEM_WAIT=2: memAccess_MEM held → 2 cycles with pc_en=exmem_en=0, memwb_bubble=1, then a release cycle with all enables 1; stall_count=2. Back-to-back loads → 4 stall cycles total.
- Branch + load-use same cycle: branchTaken_EX=1 and `lu`=1 → ifid_flush=1, idex_bubble=1, pc_en=1; flush_count=1, stall_count unchanged.
- Branch during WAIT: branchTaken_EX=1 while memstall → no flush until the release cycle, then exactly one flush.
- Reset mid-WAIT (cnt=1) → state RUN, counters 0; after deassert, memAccess_MEM=0 gives all enables 1.
